// File: rtl/mem_io_responder_pkg.sv
// Shared constants, read-select encoding and byte helper for mem_io_responder.
package mem_io_responder_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 32;

  localparam logic [1:0]  IO_SEL       = 2'b11;
  localparam logic [17:0] IO_UART_ADDR = 18'h30000;
  localparam logic [17:0] IO_CLK_ADDR  = 18'h30004;

  typedef enum logic [2:0] {
    RD_RAM,
    RD_UART,
    RD_CLK0,
    RD_CLK1,
    RD_CLK2,
    RD_CLK3,
    RD_OTHER
  } rd_sel_t;

  function automatic logic [DATA_W-1:0] snap_byte(input logic [31:0] snap, input logic [1:0] n);
    logic [31:0] sh;
    sh = snap >> {n, 3'b000};
    return sh[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/io_tx_fifo.sv
// Byte FIFO with circular pointers; a push into a full FIFO is accepted only alongside a pop.
module io_tx_fifo #(
  parameter int LOG = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [7:0]   din,
  output logic [7:0]   dout,
  output logic [LOG:0] count,
  output logic [LOG:0] count_next,
  output logic         empty,
  output logic         full
);

  localparam int DEPTH = 1 << LOG;

  logic [7:0]     mem [0:DEPTH-1];
  logic [LOG-1:0] wr_ptr;
  logic [LOG-1:0] rd_ptr;
  logic           push_ok;
  logic           pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (LOG+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (push_ok && !pop_ok) count_next = count + 1'b1;
    if (pop_ok && !push_ok) count_next = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

endmodule

// File: rtl/mem_io_responder.sv
// Memory-side responder: 128KB RAM plus UART/cycle-clock I/O window for the cpu byte bus.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int RAM_AW  = 17,
  parameter int TXQ_LOG = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] iCPU_addr,
  input  logic        iCPU_wr,
  input  logic [7:0]  iCPU_dt,
  output logic [7:0]  oCPU_dt,
  output logic        oCPU_io_buffer_full,
  output logic        oTX_en,
  output logic [7:0]  oTX_dt,
  input  logic        iTX_ready,
  input  logic        iRX_en,
  input  logic [7:0]  iRX_dt,
  output logic        oProgram_stop
);

  localparam int DEPTH = 1 << TXQ_LOG;

  logic [7:0]  ram [0:(1<<RAM_AW)-1];
  logic [7:0]  ram_q;
  rd_sel_t     rd_sel;
  logic [7:0]  uart_q;
  logic [31:0] cyc_cnt;
  logic [31:0] snapshot;
  logic        rx_valid;
  logic [7:0]  rx_data;

  logic [17:0] a;
  logic        is_io, uart_hit, clk_hit, stop_hit;
  logic        push, pop;
  logic [7:0]  push_data, head;
  logic [TXQ_LOG:0] count, count_next;
  logic        empty, full;

  wire unused_addr = &{1'b0, iCPU_addr[31:18], count, full};

  assign a         = iCPU_addr[17:0];
  assign is_io     = (a[17:16] == IO_SEL);
  assign uart_hit  = (a == IO_UART_ADDR);
  assign clk_hit   = (a[17:2] == IO_CLK_ADDR[17:2]);
  assign stop_hit  = (a == IO_CLK_ADDR);
  // The stop write pushes a literal zero, so it bypasses the zero filter.
  assign push      = iCPU_wr && ((uart_hit && iCPU_dt != 8'h00) || stop_hit);
  assign push_data = uart_hit ? iCPU_dt : 8'h00;
  assign pop       = !empty && iTX_ready;

  io_tx_fifo #(.LOG(TXQ_LOG)) u_tx_fifo (
    .clk        (clk_in),
    .rst        (rst_in),
    .push       (push),
    .pop        (pop),
    .din        (push_data),
    .dout       (head),
    .count      (count),
    .count_next (count_next),
    .empty      (empty),
    .full       (full)
  );

  always_ff @(posedge clk_in) begin
    if (iCPU_wr && !is_io) ram[iCPU_addr[RAM_AW-1:0]] <= iCPU_dt;
    ram_q <= ram[iCPU_addr[RAM_AW-1:0]];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rd_sel              <= RD_OTHER;
      uart_q              <= 8'h00;
      cyc_cnt             <= 32'h0;
      snapshot            <= 32'h0;
      rx_valid            <= 1'b0;
      rx_data             <= 8'h00;
      oCPU_io_buffer_full <= 1'b0;
      oTX_en              <= 1'b0;
      oTX_dt              <= 8'h00;
      oProgram_stop       <= 1'b0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'h1;

      if (iCPU_wr)      rd_sel <= RD_OTHER;
      else if (!is_io)  rd_sel <= RD_RAM;
      else if (uart_hit) rd_sel <= RD_UART;
      else if (clk_hit) begin
        case (a[1:0])
          2'd0:    rd_sel <= RD_CLK0;
          2'd1:    rd_sel <= RD_CLK1;
          2'd2:    rd_sel <= RD_CLK2;
          default: rd_sel <= RD_CLK3;
        endcase
      end else rd_sel <= RD_OTHER;

      // A byte arriving during a read replaces the one being returned and stays valid.
      if (!iCPU_wr && uart_hit) uart_q <= rx_valid ? rx_data : 8'h00;
      if (iRX_en) begin
        rx_valid <= 1'b1;
        rx_data  <= iRX_dt;
      end else if (!iCPU_wr && uart_hit) begin
        rx_valid <= 1'b0;
      end

      if (!iCPU_wr && stop_hit) snapshot <= cyc_cnt;
      if (iCPU_wr && stop_hit) oProgram_stop <= 1'b1;

      oCPU_io_buffer_full <= (count_next >= (TXQ_LOG+1)'(DEPTH - 2));
      oTX_en <= pop;
      if (pop) oTX_dt <= head;
    end
  end

  always_comb begin
    oCPU_dt = 8'h00;
    case (rd_sel)
      RD_RAM:  oCPU_dt = ram_q;
      RD_UART: oCPU_dt = uart_q;
      RD_CLK0: oCPU_dt = snap_byte(snapshot, 2'd0);
      RD_CLK1: oCPU_dt = snap_byte(snapshot, 2'd1);
      RD_CLK2: oCPU_dt = snap_byte(snapshot, 2'd2);
      RD_CLK3: oCPU_dt = snap_byte(snapshot, 2'd3);
      default: oCPU_dt = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench for mem_io_responder: queued read/TX expectations checked by a monitor.
module tb_mem_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [31:0] iCPU_addr = 32'h0;
  logic        iCPU_wr = 1'b0;
  logic [7:0]  iCPU_dt = 8'h00;
  logic [7:0]  oCPU_dt;
  logic        oCPU_io_buffer_full;
  logic        oTX_en;
  logic [7:0]  oTX_dt;
  logic        iTX_ready = 1'b1;
  logic        iRX_en = 1'b0;
  logic [7:0]  iRX_dt = 8'h00;
  logic        oProgram_stop;

  mem_io_responder dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .iCPU_addr           (iCPU_addr),
    .iCPU_wr             (iCPU_wr),
    .iCPU_dt             (iCPU_dt),
    .oCPU_dt             (oCPU_dt),
    .oCPU_io_buffer_full (oCPU_io_buffer_full),
    .oTX_en              (oTX_en),
    .oTX_dt              (oTX_dt),
    .iTX_ready           (iTX_ready),
    .iRX_en              (iRX_en),
    .iRX_dt              (iRX_dt),
    .oProgram_stop       (oProgram_stop)
  );

  always #5 clk_in = ~clk_in;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] rd_exp[$];
  logic [7:0] tx_exp[$];
  logic       chk_rd = 1'b0;
  logic       rd_flag = 1'b0;
  logic [7:0] mon_rd_e;
  logic [7:0] mon_tx_e;

  always @(posedge clk_in) rd_flag <= chk_rd;

  always @(negedge clk_in) begin
    if (rd_flag) begin
      tests++;
      if (rd_exp.size() == 0) begin
        fails++;
        $display("FAIL rd_data: got %02h, no read expected", oCPU_dt);
      end else begin
        mon_rd_e = rd_exp.pop_front();
        if (oCPU_dt !== mon_rd_e) begin
          fails++;
          $display("FAIL rd_data: got %02h, expected %02h", oCPU_dt, mon_rd_e);
        end
      end
    end
    if (oTX_en !== 1'b0) begin
      tests++;
      if (tx_exp.size() == 0) begin
        fails++;
        $display("FAIL tx_byte: got en=%b dt=%02h, no byte expected", oTX_en, oTX_dt);
      end else begin
        mon_tx_e = tx_exp.pop_front();
        if (oTX_en !== 1'b1 || oTX_dt !== mon_tx_e) begin
          fails++;
          $display("FAIL tx_byte: got en=%b dt=%02h, expected %02h", oTX_en, oTX_dt, mon_tx_e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic bus(input logic [31:0] addr, input logic wr, input logic [7:0] dt,
                     input logic chk, input logic [7:0] exp,
                     input logic rx_en, input logic [7:0] rx_dt);
    iCPU_addr = addr;
    iCPU_wr   = wr;
    iCPU_dt   = dt;
    iRX_en    = rx_en;
    iRX_dt    = rx_dt;
    chk_rd    = chk;
    if (chk) rd_exp.push_back(exp);
    @(posedge clk_in);
    #1;
    iCPU_addr = 32'h0;
    iCPU_wr   = 1'b0;
    iCPU_dt   = 8'h00;
    iRX_en    = 1'b0;
    chk_rd    = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [7:0] dt);
    bus(addr, 1'b1, dt, 1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [7:0] exp);
    bus(addr, 1'b0, 8'h00, 1'b1, exp, 1'b0, 8'h00);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) bus(32'h0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic do_reset(input string tag);
    rst_in = 1'b1;
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    check({tag, "_cpu_dt"}, {24'h0, oCPU_dt}, 32'h00);
    check({tag, "_buf_full"}, {31'h0, oCPU_io_buffer_full}, 32'h0);
    check({tag, "_tx_en"}, {31'h0, oTX_en}, 32'h0);
    check({tag, "_tx_dt"}, {24'h0, oTX_dt}, 32'h00);
    check({tag, "_stop"}, {31'h0, oProgram_stop}, 32'h0);
  endtask

  initial begin
    do_reset("reset");

    // RAM write then read-back, including the top byte of the array
    wr(32'h0000_0010, 8'h5A);
    rd(32'h0000_0010, 8'h5A);
    wr(32'h0001_FFFF, 8'hC3);
    rd(32'h0001_FFFF, 8'hC3);
    rd(32'h0000_0010, 8'h5A);
    wr(32'h0003_0010, 8'h77);
    rd(32'h0003_0010, 8'h00);

    // UART: one real byte, the zero write is filtered
    iTX_ready = 1'b1;
    tx_exp.push_back(8'h41);
    wr(32'h0003_0000, 8'h41);
    wr(32'h0003_0000, 8'h00);
    idle(4);

    // Backpressure: 8-deep FIFO, full flag from 6 entries, pushes 9 and 10 dropped
    iTX_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (i <= 8) tx_exp.push_back(8'(i));
      wr(32'h0003_0000, 8'(i));
      if (i == 5) check("buf_full_at5", {31'h0, oCPU_io_buffer_full}, 32'h0);
      if (i == 6) check("buf_full_at6", {31'h0, oCPU_io_buffer_full}, 32'h1);
      if (i == 10) check("buf_full_at10", {31'h0, oCPU_io_buffer_full}, 32'h1);
    end
    iTX_ready = 1'b1;
    idle(12);
    check("buf_full_drained", {31'h0, oCPU_io_buffer_full}, 32'h0);
    check("tx_drained", tx_exp.size(), 32'h0);

    // RX holding register
    bus(32'h0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h62);
    rd(32'h0003_0000, 8'h62);
    rd(32'h0003_0000, 8'h00);
    bus(32'h0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h64);
    bus(32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h64, 1'b1, 8'h63);
    rd(32'h0003_0000, 8'h63);
    rd(32'h0003_0000, 8'h00);

    // Program stop: sticky flag plus a zero byte to the UART
    tx_exp.push_back(8'h00);
    wr(32'h0003_0004, 8'hFF);
    idle(3);
    check("stop_set", {31'h0, oProgram_stop}, 32'h1);
    idle(5);
    check("stop_sticky", {31'h0, oProgram_stop}, 32'h1);
    check("stop_tx_seen", tx_exp.size(), 32'h0);
    do_reset("rst2");

    // Cycle clock: snapshot taken at count 0x123, bytes read little-endian
    idle(32'h123);
    rd(32'h0003_0004, 8'h23);
    rd(32'h0003_0005, 8'h01);
    rd(32'h0003_0006, 8'h00);
    rd(32'h0003_0007, 8'h00);

    idle(4);
    check("rd_queue_empty", rd_exp.size(), 32'h0);
    check("tx_queue_empty", tx_exp.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
